// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues RV32M multiplies to a multi-cycle multiplier, stalls until the product returns (optional MUL_ZERO_BYPASS_EN)
module mul_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  input  logic        mul_ready,
  input  logic [31:0] mul_res,
  output logic [2:0]  mulsel,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
  state_t state, state_nx;
  logic [2:0] sel;
  logic [CNT_W-1:0] cnt;
  logic is_mul, accept, zero_op, expired, done_ok, done_to;
  assign is_mul = valid_in && opcode == 7'b0110011 && funct7 == 7'b0000001 && !funct3[2];
  assign accept = state == IDLE && is_mul && !flush;
`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = rs1_data == '0 || rs2_data == '0;
`else
  assign zero_op = 1'b0;
`endif
  assign expired = cnt == CNT_W'(TIMEOUT_CYCLES);
  assign done_ok = state == RUN && !flush && mul_ready;
  assign done_to = state == RUN && !flush && !mul_ready && expired;
  assign mulsel = state == RUN ? sel : 3'd0;
  assign stall = is_mul && !flush && !wb_valid;
  always_comb begin
    state_nx = state == RELEASE ? IDLE
             : state == RUN ? ((flush || mul_ready || expired) ? RELEASE : RUN)
             : accept ? (zero_op ? RELEASE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      mul_a <= '0;
      mul_b <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      wb_valid <= done_ok || done_to || (accept && zero_op);
      timeout_err <= done_to;
      if (accept) begin
        mul_a <= rs1_data;
        mul_b <= rs2_data;
        sel <= {1'b0, funct3[1:0]} + 3'd1;
        wb_rd <= rd_addr;
      end
      if (done_ok) wb_data <= mul_res;
      else if (done_to || (accept && zero_op)) wb_data <= '0;
    end
  end
endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sits in EX, directly upstream of the multi-cycle multiplier.
- Decodes RV32M multiply instructions from the ID/EX register and latches their operands.
- Drives the multiplier's op-select and operand inputs, and stalls the pipeline until the product returns.
- Captures the result and presents a one-cycle writeback pulse, then idles the multiplier for one cycle before the next op.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles spent in RUN waiting for mul_ready before the op is aborted.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  ID/EX holds a valid instruction.
- opcode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- rs1_data  in  32  operand A.
- rs2_data  in  32  operand B.
- rd_addr  in  5  destination register.
- flush  in  1  pipeline flush; aborts any in-flight op.
- mul_ready  in  1  multiplier ready.
- mul_res  in  32  multiplier result.
- mulsel  out  3  multiplier op select: 0 idle, 1 mul, 2 mulh, 3 mulhsu, 4 mulhu.
- mul_a  out  32  latched operand A.
- mul_b  out  32  latched operand B.
- stall  out  1  hold the IF/ID/EX pipeline registers.
- wb_valid  out  1  one-cycle result-valid pulse.
- wb_rd  out  5  destination register for the result.
- wb_data  out  32  result data.
- timeout_err  out  1  one-cycle pulse when an op times out.

Behaviour:
- Decode: is_mul = valid_in & opcode==7'b0110011 & funct7==7'b0000001 & funct3[2]==0.
  - funct3 000→mulsel 1, 001→2, 010→3, 011→4.
  - funct3 1xx (div/rem) is not this block's concern; is_mul=0.
- Reset (rst=1 at a rising edge): state=IDLE; mulsel, mul_a, mul_b, wb_*, timeout_err, counter all 0. Reset mid-op discards the op with no wb_valid; mulsel=0 in the following cycle clears the multiplier.
- States:
  - IDLE: if is_mul & !flush, latch operands, rd and decoded sel, clear the counter, go to RUN. mulsel output=0 in IDLE.
  - RUN: mulsel=latched sel; counter increments each cycle.
    - mul_ready=1 → capture wb_data=mul_res, wb_rd; wb_valid<=1; go to RELEASE.
    - Else if counter==TIMEOUT_CYCLES → wb_data=0, wb_valid<=1, timeout_err<=1; go to RELEASE.
  - RELEASE: mulsel=0 for exactly one cycle, so the multiplier returns to its reset state; go to IDLE. No accept in RELEASE.
- Priority: flush > ready/timeout. flush in RUN → RELEASE with no wb_valid and no timeout_err.
- stall = is_mul & !flush & !wb_valid (combinational). It drops in the wb_valid cycle so the pipeline advances on that edge.
- wb_valid and timeout_err are registered, single-cycle pulses, and are 0 in every other cycle.
- Latency (cycle C0 = mul presented in IDLE):
  - C0–C3: stall=1.
  - C1: mulsel driven.
  - C3: mul_ready observed.
  - C4: wb_valid=1, mulsel=0.
  - C5: IDLE.
  - Back-to-back muls issue every 5 cycles.
- mul_a and mul_b are held constant from the accept edge until state leaves RUN. They are not required to clear.
- A non-mul instruction never asserts stall or touches mulsel.

Optional Feature:
- MUL_ZERO_BYPASS_EN defined: in IDLE, an accepted op with rs1_data==0 or rs2_data==0 skips RUN.
  - wb_data=0, wb_valid=1 in C1, state→RELEASE, stall only in C0.
  - mulsel stays 0 throughout.
- Undefined: zero operands follow the normal RUN path.

Test Plan:
- Reset: hold rst 2 cycles mid-RUN → mulsel=0, stall=0 (no mul presented), wb_valid never pulses; next mul completes normally.
- mul 7*6, rd=5 → stall high C0–C3, mulsel=1 in C1–C3, wb_valid in C4 with wb_data=42, wb_rd=5; mulsel=0 in C4.
- mulh a=0xFFFFFFFE (-2), b=3 → wb_data=0xFFFFFFFF. mulhu 0xFFFFFFFF*0xFFFFFFFF → wb_data=0xFFFFFFFE. mulhsu a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- Back-to-back mul then mulhu → second accept in C5, second wb_valid in C9, exactly one wb_valid per instruction.
- flush in C2 of a mul → state RELEASE, no wb_valid; mul_ready is tied 0 after flush → no timeout_err.
- mul_ready tied 0 → timeout_err and wb_valid with wb_data=0 after 15 RUN cycles; with MUL_ZERO_BYPASS_EN, mul 0*123 → wb_valid in C1, wb_data=0, mulsel never nonzero.
